// File: rtl/sr_pattern_driver.sv
// Pattern replay engine that drives an SR flip-flop and checks Q/Q_n against a reference model.
// Optional build macro SR_ILLEGAL_CHK_EN: suppress and flag S=R=1 entries instead of driving them.
module sr_pattern_driver #(
    parameter  int DEPTH = 16,
    parameter  int CNT_W = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             wr_en_in,
    input  logic [AW-1:0]    wr_addr_in,
    input  logic [1:0]       wr_data_in,
    input  logic [AW:0]      len_in,
    input  logic             start_in,
    output logic             s_out,
    output logic             r_out,
    input  logic             q_in,
    input  logic             q_n_in,
    output logic             busy_out,
    output logic             done_out,
    output logic             pass_out,
    output logic [CNT_W-1:0] err_cnt_out,
    output logic             illegal_out
);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        CHECK,
        DONE
    } state_t;

    state_t     state;
    logic [1:0] pattern [DEPTH];
    logic [AW:0] len;
    logic [AW:0] idx;
    logic [AW:0] idx_inc;
    logic [AW:0] len_clamped;
    logic [1:0] cur;
    logic [1:0] first_entry;
    logic [1:0] next_entry;
    logic       model_q;
    logic       model_valid;
    logic       mismatch;
    logic [CNT_W-1:0] err_next;

    function automatic logic [1:0] drive_of(input logic [1:0] entry);
`ifdef SR_ILLEGAL_CHK_EN
        return (entry == 2'b11) ? 2'b00 : entry;
`else
        return entry;
`endif
    endfunction

    // A write landing on entry 0 in the start cycle is forwarded so step 0 sees it.
    always_comb begin
        first_entry = pattern[0];
        if (wr_en_in && (wr_addr_in == '0))
            first_entry = wr_data_in;
        idx_inc     = idx + 1'b1;
        next_entry  = pattern[idx_inc[AW-1:0]];
        len_clamped = (len_in > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : len_in;
        mismatch    = (q_in != model_q) || (q_n_in != ~model_q);
        err_next    = err_cnt_out;
        if (model_valid && mismatch && (err_cnt_out != '1))
            err_next = err_cnt_out + 1'b1;
    end

    always_ff @(posedge clk_in) begin
        if ((state == IDLE) && wr_en_in)
            pattern[wr_addr_in] <= wr_data_in;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state       <= IDLE;
            s_out       <= 1'b0;
            r_out       <= 1'b0;
            busy_out    <= 1'b0;
            done_out    <= 1'b0;
            pass_out    <= 1'b0;
            err_cnt_out <= '0;
            model_q     <= 1'b0;
            model_valid <= 1'b0;
            idx         <= '0;
            len         <= '0;
            cur         <= '0;
`ifdef SR_ILLEGAL_CHK_EN
            illegal_out <= 1'b0;
`endif
        end else begin
            done_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_in && (len_in != '0)) begin
                        len            <= len_clamped;
                        idx            <= '0;
                        err_cnt_out    <= '0;
                        cur            <= first_entry;
                        {s_out, r_out} <= drive_of(first_entry);
                        busy_out       <= 1'b1;
                        state          <= DRIVE;
`ifdef SR_ILLEGAL_CHK_EN
                        illegal_out    <= 1'b0;
`endif
                    end
                end
                DRIVE: begin
                    case (cur)
                        2'b10: begin
                            model_q     <= 1'b1;
                            model_valid <= 1'b1;
                        end
                        2'b01: begin
                            model_q     <= 1'b0;
                            model_valid <= 1'b1;
                        end
                        2'b11: begin
`ifdef SR_ILLEGAL_CHK_EN
                            illegal_out <= 1'b1;
`else
                            model_valid <= 1'b0;
`endif
                        end
                        default: ;
                    endcase
                    {s_out, r_out} <= 2'b00;
                    state          <= CHECK;
                end
                CHECK: begin
                    err_cnt_out <= err_next;
                    idx         <= idx_inc;
                    if (idx_inc == len) begin
                        busy_out <= 1'b0;
                        done_out <= 1'b1;
                        pass_out <= (err_next == '0);
                        state    <= DONE;
                    end else begin
                        cur            <= next_entry;
                        {s_out, r_out} <= drive_of(next_entry);
                        state          <= DRIVE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifndef SR_ILLEGAL_CHK_EN
    assign illegal_out = 1'b0;
`endif

endmodule
